// File: rtl/mux_sel_scanner.sv
// Round-robin select sequencer for the 4:1 channel mux: walks the enabled
// channels, holds each for a programmable dwell and flags channel/scan ends.
module mux_sel_scanner #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [3:0]         ch_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               sel_valid,
    output logic               ch_done,
    output logic               wrap,
    output logic               busy
);

    localparam int NUM_CH = 4;
    localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

    typedef enum logic {
        IDLE,
        DWELL
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] load;
    logic [1:0]         next_sel;
    logic [1:0]         first_sel;
    logic               found;
    logic               last;
    logic [1:0]         idx;

    // A dwell of zero still holds the channel for one cycle.
    assign load = (dwell == '0) ? ONE : dwell;

    // Search sel+1, sel+2, ... so that a lone enabled channel selects itself.
    always_comb begin
        next_sel = sel;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = sel + 2'(k);
            if (!found && ch_en[idx]) begin
                next_sel = idx;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        first_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_en[i]) first_sel = 2'(i);
        end
    end

    // A pending stop suppresses the end-of-channel flags for this cycle.
    assign last    = (state == DWELL) && (count == ONE);
    assign ch_done = last && !stop;
    assign wrap    = ch_done && (ch_en != 4'b0000) && (next_sel <= sel);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop && (ch_en != 4'b0000)) begin
                        state     <= DWELL;
                        sel       <= first_sel;
                        count     <= load;
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                DWELL: begin
                    if (stop) begin
                        state     <= IDLE;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        count     <= '0;
                    end else if (last) begin
                        if (ch_en == 4'b0000) begin
                            state     <= IDLE;
                            sel_valid <= 1'b0;
                            busy      <= 1'b0;
                            count     <= '0;
                        end else begin
                            sel   <= next_sel;
                            count <= load;
                        end
                    end else begin
                        count <= count - ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Scoreboard bench for mux_sel_scanner: a cycle-level reference model pushes
// the expected outputs of every cycle, and a monitor on the falling edge checks them.
module tb_mux_sel_scanner;

    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [3:0]         ch_en = 4'b0000;
    logic [DWELL_W-1:0] dwell = '0;
    logic [1:0]         sel;
    logic               sel_valid;
    logic               ch_done;
    logic               wrap;
    logic               busy;

    typedef struct packed {
        logic [1:0] sel;
        logic       sel_valid;
        logic       ch_done;
        logic       wrap;
        logic       busy;
    } expect_t;

    expect_t exp_q[$];
    int      n_compared = 0;
    int      n_mismatched = 0;
    bit      done = 1'b0;

    // Reference model: is a scan running, which channel, how many cycles remain.
    bit      m_active = 1'b0;
    int      m_cur = 0;
    int      m_left = 0;

    mux_sel_scanner #(.DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .ch_en     (ch_en),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .ch_done   (ch_done),
        .wrap      (wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int next_channel(int cur, logic [3:0] en);
        for (int k = 1; k <= 4; k++) begin
            if (en[(cur + k) % 4]) return (cur + k) % 4;
        end
        return -1;
    endfunction

    function automatic int lowest_channel(logic [3:0] en);
        for (int i = 0; i < 4; i++) begin
            if (en[i]) return i;
        end
        return -1;
    endfunction

    function automatic int hold_len(logic [DWELL_W-1:0] d);
        return (d == 0) ? 1 : int'(d);
    endfunction

    // One clock cycle: drive inputs, record what the outputs must be during
    // this cycle, then step the model across the coming rising edge.
    task automatic applyStimulus(input bit r, input bit s, input bit p,
                                 input logic [3:0] en, input int d);
        expect_t e;
        bit      last;
        int      nxt;
        @(posedge clk);
        #1;
        rst_n = r;
        start = s;
        stop  = p;
        ch_en = en;
        dwell = DWELL_W'(d);

        last = m_active && (m_left == 1) && !p;
        nxt  = next_channel(m_cur, en);
        e.sel       = 2'(m_cur);
        e.sel_valid = m_active;
        e.busy      = m_active;
        e.ch_done   = last;
        e.wrap      = last && (en != 4'b0000) && (nxt <= m_cur);
        exp_q.push_back(e);

        if (!r) begin
            m_active = 1'b0;
            m_cur    = 0;
            m_left   = 0;
        end else if (!m_active) begin
            if (s && !p && en != 4'b0000) begin
                m_active = 1'b1;
                m_cur    = lowest_channel(en);
                m_left   = hold_len(DWELL_W'(d));
            end
        end else if (p) begin
            m_active = 1'b0;
        end else if (m_left == 1) begin
            if (en == 4'b0000) begin
                m_active = 1'b0;
            end else begin
                m_cur  = nxt;
                m_left = hold_len(DWELL_W'(d));
            end
        end else begin
            m_left = m_left - 1;
        end
    endtask

    task automatic checkOutput(input expect_t e);
        expect_t a;
        a = '{sel: sel, sel_valid: sel_valid, ch_done: ch_done, wrap: wrap, busy: busy};
        n_compared++;
        if (a !== e) begin
            n_mismatched++;
            $display("[TB] FAIL cycle_outputs at %0t: got sel=%0d valid=%b done=%b wrap=%b busy=%b, expected sel=%0d valid=%b done=%b wrap=%b busy=%b",
                     $time, a.sel, a.sel_valid, a.ch_done, a.wrap, a.busy,
                     e.sel, e.sel_valid, e.ch_done, e.wrap, e.busy);
        end
    endtask

    // Monitor: every cycle presents outputs, so every falling edge pops one entry.
    always @(negedge clk) begin
        if (!done && rst_n !== 1'bx) begin
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        // Reset, then start with nothing enabled must stay idle.
        repeat (2) applyStimulus(0, 0, 0, 4'b0000, 0);
        repeat (3) applyStimulus(1, 1, 0, 4'b0000, 3);

        // All channels, dwell 3: full round with wrap on channel 3.
        applyStimulus(1, 1, 0, 4'b1111, 3);
        repeat (14) applyStimulus(1, 0, 0, 4'b1111, 3);
        applyStimulus(1, 0, 1, 4'b1111, 3);
        applyStimulus(1, 0, 0, 4'b1111, 3);

        // Channels 1 and 3 with dwell 2, then dwell 0 toggles every cycle.
        applyStimulus(1, 1, 0, 4'b1010, 2);
        repeat (9) applyStimulus(1, 0, 0, 4'b1010, 2);
        repeat (8) applyStimulus(1, 0, 0, 4'b1010, 0);
        applyStimulus(1, 0, 1, 4'b1010, 0);

        // Single channel: sel constant, done and wrap every 4th cycle.
        applyStimulus(1, 1, 0, 4'b0100, 4);
        repeat (12) applyStimulus(1, 0, 0, 4'b0100, 4);

        // Stop coinciding with the last dwell cycle, then start+stop in idle.
        applyStimulus(1, 1, 0, 4'b1111, 2);
        applyStimulus(1, 0, 0, 4'b1111, 2);
        applyStimulus(1, 0, 1, 4'b1111, 2);
        applyStimulus(1, 1, 0, 4'b1111, 2);
        applyStimulus(1, 0, 0, 4'b1111, 2);
        applyStimulus(1, 0, 1, 4'b1111, 2);
        repeat (3) applyStimulus(1, 1, 1, 4'b1111, 2);

        // Mask cleared mid-dwell: channel finishes, then idle.
        applyStimulus(1, 1, 0, 4'b0011, 5);
        applyStimulus(1, 0, 0, 4'b0011, 5);
        repeat (6) applyStimulus(1, 0, 0, 4'b0000, 5);

        // Dwell shortened mid-channel only affects the next channel.
        applyStimulus(1, 1, 0, 4'b0011, 5);
        applyStimulus(1, 0, 0, 4'b0011, 5);
        repeat (9) applyStimulus(1, 0, 0, 4'b0011, 2);

        // Reset pulse mid-dwell.
        applyStimulus(0, 0, 0, 4'b0011, 2);
        repeat (3) applyStimulus(1, 0, 0, 4'b0011, 2);
        applyStimulus(1, 1, 0, 4'b0000, 2);
        applyStimulus(1, 0, 0, 4'b0000, 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 15) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
                          ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 4)));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
        end
        if (n_compared < 12) begin
            n_mismatched++;
            $display("[TB] FAIL compare_count: got %0d, expected at least 12", n_compared);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
